ifb_fetch_scheduler: RTL
========================

// Module: ifb_fetch_scheduler
// PURPOSE
//  Sequences instruction-fetch requests from the IFB (instruction fetch buffer) to the icache.
//  Owns the IFB slot pointers and per-slot state; issues the oldest un-issued slot to the icache;
//  tracks icache requests in flight; matches responses to slots by index and epoch.
//  Sits between the BPU/PC-gen (alloc side), the icache (req/resp) and the IFB data array (fill/deq).
// PARAMETERS
//  DEPTH    32  IFB slots, power of 2; IDX_W = $clog2(DEPTH)
//  MAX_OUT   4  max icache requests in flight (1..DEPTH)
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      async reset, active-low
//  flush         in   1      sync; drop all slots, toggle epoch
//  alloc_valid   in   1      new fetch group from PC-gen
//  alloc_pc      in   32     fetch PC of new group
//  alloc_ready   out  1      slot free (count < DEPTH)
//  alloc_idx     out  IDX_W  slot written on alloc fire (= tail)
//  req_valid     out  1      icache request valid
//  req_ready     in   1      icache accepts
//  req_pc        out  32     PC of issued slot
//  req_idx       out  IDX_W  slot index sent with request
//  req_epoch     out  1      current epoch sent with request
//  resp_valid    in   1      icache returns a group
//  resp_idx      in   IDX_W  slot index of returned group
//  resp_epoch    in   1      epoch echoed by icache
//  fill_valid    out  1      write returned instrs into IFB[fill_idx]
//  fill_idx      out  IDX_W  slot to fill
//  head_idx      out  IDX_W  oldest slot
//  head_done     out  1      head slot FILLED, may be dequeued
//  deq           in   1      consumer pops head; legal only when head_done
//  out_cnt       out  $clog2(MAX_OUT+1)  icache requests in flight
//  protocol_err  out  1      sticky: bad resp or illegal deq
// BEHAVIOUR
//  Reset: all slots FREE; head/tail/count/epoch/out_cnt = 0; alloc_ready=1; req_valid, fill_valid,
//   head_done, protocol_err = 0.
//  Slot FSM: FREE -alloc-> WAIT -req fire-> INFLT -resp match-> FILLED -deq-> FREE.
//  Alloc fire = alloc_valid & alloc_ready: slot[tail]=WAIT, pc stored, tail+1 (wraps mod DEPTH), count+1.
//  Full: count==DEPTH -> alloc_ready=0, even if deq same cycle (no full-bypass).
//  Issue: req_valid = (some WAIT slot) & out_cnt<MAX_OUT & !flush; req_idx = first WAIT slot scanning
//   head, head+1, ... (oldest first, wraps). Outputs combinational from registered state; held stable
//   until fire unless flush. Fire: slot->INFLT, out_cnt+1.
//  Response: any resp_valid decrements out_cnt (stale or not). Accepted iff resp_epoch==epoch and
//   slot[resp_idx]==INFLT: slot->FILLED at same edge; fill_valid/fill_idx registered, asserted the
//   following cycle for exactly 1 cycle. Otherwise drop; if epoch matched, set protocol_err.
//  Same-cycle req fire and resp: out_cnt unchanged. out_cnt at MAX_OUT: no issue that cycle even if
//   resp arrives (count is registered).
//  head_done = slot[head]==FILLED. deq & head_done: slot->FREE, head+1, count-1. deq & !head_done:
//   ignored, protocol_err set. Alloc+deq same cycle: count unchanged.
//  flush (priority over all except reset): all slots FREE, head=tail=count=0, epoch toggles,
//   fill_valid cleared next cycle; out_cnt NOT cleared (stale responses still drain and decrement it).
//  Reset mid-operation: async return to reset state; in-flight icache responses are the icache's
//   responsibility (icache is reset with the same rst_n).
// CONFIGURATION
//  IFB_ISSUE_BYPASS_EN defined: when no WAIT slot exists and alloc fires, the new slot is issued in the
//   same cycle (req_pc=alloc_pc, req_idx=tail; slot goes straight to INFLT on req fire).
//  Undefined: minimum alloc->req_valid latency is 1 cycle.
// STRUCTURE
//  Package ifu_pkg: ifb_slot_e {FREE, WAIT, INFLT, FILLED}, IFB_DEPTH, IFB_IDX_W,
//   ifb_req_t {pc, idx, epoch}.
//  Sub-module ifb_oldest_pick: rotating-priority first-set finder (DEPTH-bit vector, start=head)
//   -> {found, idx}.
// TESTING
//  1 reset, 3 allocs (pc 0x1c000000/10/20), req_ready=1 -> req_idx 0,1,2 in order; out_cnt reaches 3.
//  2 MAX_OUT=4, req_ready=1, no resp, 6 allocs -> only 4 fires; resp idx 0 -> out_cnt 4->3, slot 4 issues
//   the cycle after.
//  3 resp out of order (idx 2 before 0) -> fill_valid idx 2 next cycle; head_done stays 0 until idx 0 fills.
//  4 32 allocs, no deq -> alloc_ready=0; deq+alloc same cycle -> alloc refused; next cycle accepted at
//   idx 0 (wrap).
//  5 2 slots INFLT, flush, then resp epoch=0 idx 0 -> no fill_valid, protocol_err=0, out_cnt 2->1.
//  6 deq while head WAIT -> head unchanged, protocol_err=1; with IFB_ISSUE_BYPASS_EN, alloc into empty
//   buffer -> req_valid same cycle.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared IFB types: slot state encoding, default buffer geometry and the icache request bundle.
package ifu_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    INFLT  = 2'd2,
    FILLED = 2'd3
  } ifb_slot_e;

  localparam int IFB_DEPTH = 32;
  localparam int IFB_IDX_W = $clog2(IFB_DEPTH);

  typedef struct packed {
    logic [31:0]          pc;
    logic [IFB_IDX_W-1:0] idx;
    logic                 epoch;
  } ifb_req_t;

endpackage

// File: rtl/ifb_oldest_pick.sv
// Rotating-priority first-set finder: returns the first set bit of i_vec scanning upward from
// i_start and wrapping, so the oldest waiting IFB slot wins.
module ifb_oldest_pick #(
  parameter int DEPTH = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_vec,
  input  logic [IDX_W-1:0] i_start,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_pos;

  // Scan from the far end back toward i_start so the nearest hit is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_start;
    w_pos   = i_start;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_pos = i_start + IDX_W'(k);
      if (i_vec[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/ifb_fetch_scheduler.sv
// IFB fetch scheduler: owns slot pointers/state, issues oldest waiting slot to the icache and
// matches responses by index and epoch. Optional same-cycle issue: IFB_ISSUE_BYPASS_EN.
module ifb_fetch_scheduler
  import ifu_pkg::*;
#(
  parameter int DEPTH   = IFB_DEPTH,
  parameter int MAX_OUT = 4,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_pc,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [31:0]      req_pc,
  output logic [IDX_W-1:0] req_idx,
  output logic             req_epoch,
  input  logic             resp_valid,
  input  logic [IDX_W-1:0] resp_idx,
  input  logic             resp_epoch,
  output logic             fill_valid,
  output logic [IDX_W-1:0] fill_idx,
  output logic [IDX_W-1:0] head_idx,
  output logic             head_done,
  input  logic             deq,
  output logic [CNT_W-1:0] out_cnt,
  output logic             protocol_err
);

  ifb_slot_e        r_state [DEPTH];
  logic [31:0]      r_pc    [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;
  logic             r_epoch;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_fill_valid;
  logic [IDX_W-1:0] r_fill_idx;
  logic             r_perr;

  logic [DEPTH-1:0] w_wait_vec;
  logic             w_found;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_cnt_ok;
  logic             w_alloc_fire;
  logic             w_req_fire;
  logic             w_resp_hit;
  logic             w_epoch_ok;
  logic             w_deq_fire;
  ifb_req_t         w_req;

  always_comb begin
    w_wait_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wait_vec[i] = (r_state[i] == WAIT);
    end
  end

  ifb_oldest_pick #(.DEPTH(DEPTH)) u_pick (
    .i_vec   (w_wait_vec),
    .i_start (r_head),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  assign alloc_ready  = (r_count != (IDX_W + 1)'(DEPTH));
  assign w_alloc_fire = alloc_valid & alloc_ready;
  assign w_cnt_ok     = (r_out_cnt < CNT_W'(MAX_OUT));

  // The request bundle carries a package-sized index; DEPTH must not exceed IFB_DEPTH.
`ifdef IFB_ISSUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass  = ~w_found & w_alloc_fire;
  assign req_valid = (w_found | w_bypass) & w_cnt_ok & ~flush;
  always_comb begin
    if (w_bypass) begin
      w_req = '{pc: alloc_pc, idx: IFB_IDX_W'(r_tail), epoch: r_epoch};
    end else begin
      w_req = '{pc: r_pc[w_pick_idx], idx: IFB_IDX_W'(w_pick_idx), epoch: r_epoch};
    end
  end
`else
  assign req_valid = w_found & w_cnt_ok & ~flush;
  always_comb begin
    w_req = '{pc: r_pc[w_pick_idx], idx: IFB_IDX_W'(w_pick_idx), epoch: r_epoch};
  end
`endif

  assign req_pc     = w_req.pc;
  assign req_idx    = IDX_W'(w_req.idx);
  assign req_epoch  = w_req.epoch;
  assign w_req_fire = req_valid & req_ready;

  assign w_epoch_ok = (resp_epoch == r_epoch);
  assign w_resp_hit = resp_valid & w_epoch_ok & (r_state[resp_idx] == INFLT);
  assign head_done  = (r_state[r_head] == FILLED);
  assign w_deq_fire = deq & head_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= FREE;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_epoch      <= 1'b0;
      r_out_cnt    <= '0;
      r_fill_valid <= 1'b0;
      r_fill_idx   <= '0;
      r_perr       <= 1'b0;
    end else begin
      // Stale responses still return a credit, so out_cnt survives flush.
      case ({w_req_fire, resp_valid})
        2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
        2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
        default: r_out_cnt <= r_out_cnt;
      endcase
      r_fill_valid <= w_resp_hit & ~flush;
      r_fill_idx   <= resp_idx;

      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_state[i] <= FREE;
        end
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_epoch <= ~r_epoch;
      end else begin
        if (w_alloc_fire) begin
          r_state[r_tail] <= WAIT;
          r_tail          <= r_tail + 1'b1;
        end
        // Issue after alloc so a bypassed slot lands directly in INFLT.
        if (w_req_fire) begin
          r_state[req_idx] <= INFLT;
        end
        if (w_resp_hit) begin
          r_state[resp_idx] <= FILLED;
        end else if (resp_valid && w_epoch_ok) begin
          r_perr <= 1'b1;
        end
        if (w_deq_fire) begin
          r_state[r_head] <= FREE;
          r_head          <= r_head + 1'b1;
        end else if (deq) begin
          r_perr <= 1'b1;
        end
        case ({w_alloc_fire, w_deq_fire})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc_fire) begin
      r_pc[r_tail] <= alloc_pc;
    end
  end

  assign alloc_idx    = r_tail;
  assign head_idx     = r_head;
  assign fill_valid   = r_fill_valid;
  assign fill_idx     = r_fill_idx;
  assign out_cnt      = r_out_cnt;
  assign protocol_err = r_perr;

endmodule
